// File: rtl/cr_tx_sched_if.sv
// Flow-ID bus between cr_core and the ready-flow scheduler.
// Handshake: an enq_fid is valid when != FLOW_ID_NONE and has no ready; the scheduler takes it if there is room and otherwise drops it and flags q_overflow. tx_fid_out is valid when != FLOW_ID_NONE, and tx_pause high blocks the dequeue at that edge.
interface cr_tx_sched_if #(
  parameter int FLOW_ID_W = 10,
  parameter int ADDR_W    = 10
);
  logic [FLOW_ID_W-1:0] enq_fid1;
  logic [FLOW_ID_W-1:0] enq_fid2;
  logic                 tx_pause;
  logic [FLOW_ID_W-1:0] tx_fid_out;
  logic [ADDR_W:0]      q_count;
  logic                 q_overflow;

  modport master (
    output enq_fid1, enq_fid2, tx_pause,
    input  tx_fid_out, q_count, q_overflow
  );

  modport slave (
    input  enq_fid1, enq_fid2, tx_pause,
    output tx_fid_out, q_count, q_overflow
  );
endinterface

// File: rtl/cr_tx_sched.sv
// Ready-flow scheduler: a circular FIFO that takes up to two flow IDs per cycle and returns one per cycle.
// It has no read bypass, so an ID written at one edge can leave at the next edge at the earliest.
module cr_tx_sched #(
  parameter int FLOW_ID_W = 10,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter logic [FLOW_ID_W-1:0] FLOW_ID_NONE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  cr_tx_sched_if.slave  bus
);
  localparam int CW = ADDR_W + 1;

  logic [FLOW_ID_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]    head_q, head_d;
  logic [ADDR_W-1:0]    tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [FLOW_ID_W-1:0] fid_out_q, fid_out_d;
  logic                 ovf_q, ovf_d;

  logic                 v1, v2, deq;
  logic [1:0]           n_req, n_acc;
  logic [CW-1:0]        free;
  logic                 wr0_en, wr1_en;
  logic [FLOW_ID_W-1:0] wr0_data;
  logic [ADDR_W-1:0]    tail_p1;

  always_comb begin
    v1      = (bus.enq_fid1 != FLOW_ID_NONE);
    v2      = (bus.enq_fid2 != FLOW_ID_NONE);
    deq     = ~bus.tx_pause & (count_q != '0);
    n_req   = {1'b0, v1} + {1'b0, v2};
    // A slot freed by this edge's dequeue can be refilled at the same edge.
    free    = CW'(DEPTH) - count_q + CW'(deq);
    n_acc   = (free >= CW'(n_req)) ? n_req : free[1:0];

    // The first accepted ID is fid1 when it is valid, otherwise fid2.
    wr0_en   = (n_acc != 2'd0);
    wr1_en   = (n_acc == 2'd2);
    wr0_data = v1 ? bus.enq_fid1 : bus.enq_fid2;
    tail_p1  = tail_q + ADDR_W'(1);

    head_d    = head_q;
    fid_out_d = FLOW_ID_NONE;
    if (deq) begin
      head_d    = head_q + ADDR_W'(1);
      fid_out_d = mem[head_q];
    end
    tail_d  = tail_q + ADDR_W'(n_acc);
    count_d = count_q + CW'(n_acc) - CW'(deq);
    ovf_d   = ovf_q | (n_acc != n_req);
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail_q]  <= wr0_data;
    if (wr1_en) mem[tail_p1] <= bus.enq_fid2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      fid_out_q <= FLOW_ID_NONE;
      ovf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      fid_out_q <= fid_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.tx_fid_out = fid_out_q;
  assign bus.q_count    = count_q;
  assign bus.q_overflow = ovf_q;
endmodule

// File: tb/tb_cr_tx_sched.sv
// Bench for cr_tx_sched: a vector table, directed full, wrap and reset sequences, and random traffic checked against a queue model.
module tb_cr_tx_sched;
  localparam int W     = 10;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_tx_sched_if #(.FLOW_ID_W(W), .ADDR_W(AW)) bus ();

  cr_tx_sched #(.FLOW_ID_W(W), .ADDR_W(AW), .DEPTH(DEPTH), .FLOW_ID_NONE('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Scoreboard: the queue of resident IDs and the sticky overflow flag.
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Drives one cycle, advances the model and compares all outputs #1 after the edge.
  task automatic cycle(input logic [W-1:0] f1, input logic [W-1:0] f2, input logic p);
    logic [W-1:0] exp_out;
    logic [W-1:0] offer[$];
    int sz, free;
    bit deq;
    bus.enq_fid1 = f1;
    bus.enq_fid2 = f2;
    bus.tx_pause = p;
    sz      = exp_q.size();
    deq     = !p && (sz > 0);
    free    = DEPTH - sz + (deq ? 1 : 0);
    exp_out = '0;
    if (deq) exp_out = exp_q.pop_front();
    if (f1 != '0) offer.push_back(f1);
    if (f2 != '0) offer.push_back(f2);
    foreach (offer[i]) begin
      if (i < free) exp_q.push_back(offer[i]);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    if (bus.tx_fid_out != '0) n_out++;
    check("model_out", int'(bus.tx_fid_out), int'(exp_out));
    check("model_cnt", int'(bus.q_count), exp_q.size());
    check("model_ovf", int'(bus.q_overflow), int'(exp_ovf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enq_fid1 = '0;
    bus.enq_fid2 = '0;
    bus.tx_pause = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [W-1:0] rand_id();
    if ($urandom_range(0, 9) < 3) return '0;
    return W'($urandom_range(1, (1 << W) - 1));
  endfunction

  typedef struct {
    logic [W-1:0] f1;
    logic [W-1:0] f2;
    logic         p;
    logic [W-1:0] exp_out;
    logic [AW:0]  exp_cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [W-1:0] first_id;
    int n_in;

    // Single flow, dual-enqueue ordering, then pause holding {7,8}.
    tbl[0]  = '{10'd5, 10'd0, 1'b0, 10'd0, 11'd1};
    tbl[1]  = '{10'd0, 10'd0, 1'b0, 10'd5, 11'd0};
    tbl[2]  = '{10'd0, 10'd0, 1'b0, 10'd0, 11'd0};
    tbl[3]  = '{10'd3, 10'd9, 1'b0, 10'd0, 11'd2};
    tbl[4]  = '{10'd4, 10'd0, 1'b0, 10'd3, 11'd2};
    tbl[5]  = '{10'd0, 10'd0, 1'b0, 10'd9, 11'd1};
    tbl[6]  = '{10'd0, 10'd0, 1'b0, 10'd4, 11'd0};
    tbl[7]  = '{10'd0, 10'd0, 1'b0, 10'd0, 11'd0};
    tbl[8]  = '{10'd7, 10'd8, 1'b1, 10'd0, 11'd2};
    tbl[9]  = '{10'd0, 10'd0, 1'b1, 10'd0, 11'd2};
    tbl[10] = '{10'd0, 10'd0, 1'b1, 10'd0, 11'd2};
    tbl[11] = '{10'd0, 10'd0, 1'b1, 10'd0, 11'd2};
    tbl[12] = '{10'd0, 10'd0, 1'b0, 10'd7, 11'd1};
    tbl[13] = '{10'd0, 10'd0, 1'b0, 10'd8, 11'd0};
    tbl[14] = '{10'd0, 10'd0, 1'b0, 10'd0, 11'd0};

    do_reset();
    check("reset_out", int'(bus.tx_fid_out), 0);
    check("reset_cnt", int'(bus.q_count), 0);
    check("reset_ovf", int'(bus.q_overflow), 0);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].f1, tbl[i].f2, tbl[i].p);
      check($sformatf("tbl%0d_out", i), int'(bus.tx_fid_out), int'(tbl[i].exp_out));
      check($sformatf("tbl%0d_cnt", i), int'(bus.q_count), int'(tbl[i].exp_cnt));
    end

    // Full: fill under pause, offer two that must both drop, then accept exactly one while dequeuing.
    do_reset();
    for (int k = 0; k < DEPTH; k += 2)
      cycle(W'((k % 1023) + 1), W'(((k + 1) % 1023) + 1), 1'b1);
    check("full_cnt", int'(bus.q_count), DEPTH);
    check("full_ovf_before", int'(bus.q_overflow), 0);
    cycle(10'd11, 10'd12, 1'b1);
    check("full_drop_cnt", int'(bus.q_count), DEPTH);
    check("full_drop_ovf", int'(bus.q_overflow), 1);
    first_id = 10'd1;
    cycle(10'd13, 10'd14, 1'b0);
    check("full_one_cnt", int'(bus.q_count), DEPTH);
    check("full_one_out", int'(bus.tx_fid_out), int'(first_id));
    for (int i = 0; i < DEPTH; i++) begin
      cycle('0, '0, 1'b0);
      if (i == DEPTH - 1) check("full_last_out", int'(bus.tx_fid_out), 13);
    end
    cycle('0, '0, 1'b0);
    check("full_drained_out", int'(bus.tx_fid_out), 0);
    check("full_sticky_ovf", int'(bus.q_overflow), 1);

    // Wrap: 3000 single enqueues with a ten-cycle dual-enqueue burst in the middle.
    do_reset();
    n_out = 0;
    n_in  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i >= 1500 && i < 1510) begin
        cycle(W'((i % 1000) + 1), W'((i % 1000) + 11), 1'b0);
        n_in += 2;
      end else begin
        cycle(W'((i % 1023) + 1), '0, 1'b0);
        n_in += 1;
      end
    end
    repeat (20) cycle('0, '0, 1'b0);
    check("wrap_total_out", n_out, n_in);
    check("wrap_ovf", int'(bus.q_overflow), 0);
    check("wrap_cnt", int'(bus.q_count), 0);

    // Random traffic: pause-heavy to build occupancy, then pause-light to drain.
    do_reset();
    for (int i = 0; i < 1500; i++) cycle(rand_id(), rand_id(), ($urandom_range(0, 9) < 8));
    for (int i = 0; i < 2500; i++) cycle(rand_id(), rand_id(), ($urandom_range(0, 9) < 2));
    repeat (DEPTH + 4) cycle('0, '0, 1'b0);

    // Async reset between edges while output and count are non-zero.
    do_reset();
    repeat (5) cycle(W'($urandom_range(1, 1023)), W'($urandom_range(1, 1023)), 1'b1);
    repeat (2) cycle('0, '0, 1'b0);
    check("pre_rst_cnt", int'(bus.q_count), 8);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(bus.tx_fid_out), 0);
    check("async_rst_cnt", int'(bus.q_count), 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) begin
      cycle('0, '0, 1'b0);
      check("post_rst_out", int'(bus.tx_fid_out), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cr_tx_sched.md
# cr_tx_sched

Ready-flow scheduler for the cwnd credit engine. It absorbs the up to two "flow became transmittable" notifications that `cr_core` produces each cycle (`tx_enq_fid1`, `tx_enq_fid2`). It holds those flow IDs in a circular FIFO and returns one flow ID per cycle to `cr_core`'s `tx_fid_in` port, in FIFO order. It is the issuing end of the `tx_fid` / `tx_enq_fid` loop and sits between `cr_core` and the data-path pacing logic.

## Interface
- `FLOW_ID_W`, default 10: flow ID width; matches `` `FLOW_ID_W ``.
- `ADDR_W`, default 10: FIFO index width.
- `DEPTH`, default 1024: FIFO entries. Must equal 2**`ADDR_W` (= `` `MAX_FLOW_CNT ``).
- `FLOW_ID_NONE`, default 0: idle/invalid flow ID value.
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enq_fid1`, in, `FLOW_ID_W`: newly ready flow, fed from `tx_enq_fid1`. Valid when != `FLOW_ID_NONE`.
- `enq_fid2`, in, `FLOW_ID_W`: re-armed flow, fed from `tx_enq_fid2`. Valid when != `FLOW_ID_NONE`.
- `tx_pause`, in, 1: downstream back-pressure. While high, no dequeue.
- `tx_fid_out`, out, `FLOW_ID_W`: registered flow ID to `cr_core` `tx_fid_in`. `FLOW_ID_NONE` when idle.
- `q_count`, out, `ADDR_W+1`: registered occupancy, 0..`DEPTH`.
- `q_overflow`, out, 1: sticky error; set when any valid enqueue is dropped.

## Operation
- State:
  - `mem[DEPTH]` of `FLOW_ID_W` bits.
  - `head` and `tail`, `ADDR_W` bits each; wrap modulo `DEPTH` by natural overflow.
  - `count`, `ADDR_W+1` bits.
  - `tx_fid_out` register.
  - `q_overflow` flag.
- Per-cycle valid flags: `v1 = enq_fid1 != NONE`, `v2 = enq_fid2 != NONE`.
- Dequeue: `deq = ~tx_pause & (count != 0)`.
  - If `deq`: `tx_fid_out <= mem[head]`, `head <= head+1`.
  - Otherwise `tx_fid_out <= FLOW_ID_NONE`.
  - The read is from registered array contents. An entry written this edge is not dequeueable this edge; there is no bypass.
- Enqueue ordering: `enq_fid1` is written before `enq_fid2`.
  - Both valid: `mem[tail] <= fid1`, `mem[tail+1] <= fid2`, `tail += 2`.
  - Only one valid: that ID goes to `mem[tail]`, `tail += 1`.
- Capacity: `free = DEPTH - count + deq`, computed at `ADDR_W+1` bits.
  - Accepted enqueues are limited to `min(v1+v2, free)`.
  - When space exists for only one, `fid1` is kept and `fid2` is dropped.
  - Any drop sets `q_overflow`. It clears only on reset.
- Count: `count <= count + accepted - deq`, with no wrap. Invariant: `0 <= count <= DEPTH`.
- Duplicate IDs are not filtered. `cr_core`'s `ready_to_tx` flag guarantees each flow is resident at most once.
- `q_count` mirrors `count`.
- Reset (async, `rst_n` low):
  - `head = tail = count = 0`.
  - `tx_fid_out = FLOW_ID_NONE`.
  - `q_overflow = 0`.
  - `mem` is not reset; contents are don't-care.
  - Reset mid-operation discards all queued flows immediately. The first dequeue after release requires a fresh enqueue.

## Timing
- Enqueue on edge k, queue previously empty, `tx_pause` low:
  - `tx_fid_out` shows the ID after edge k+1.
  - Minimum latency is 2 edges.
- Sustained throughput: one ID out per cycle while `count > 0` and `tx_pause` is low. Up to two IDs in per cycle.
- `tx_pause` is sampled at the edge.
  - Pause high at edge k gives `tx_fid_out = NONE` after edge k.
  - `head` and `count` hold.
- Simultaneous enqueue and dequeue at `count == DEPTH`: `free = 1`, so one ID is accepted.
- Wrap: `tail` and `head` roll from `DEPTH-1` to 0 with no bubble.
- `tx_fid_out` is held `NONE` for every cycle with no dequeue. It never repeats a stale ID.

## Test plan
- **Single flow:** reset, then `enq_fid1 = 5` for one cycle.
  - Response: `tx_fid_out = 5` exactly one cycle, two edges later, then `NONE`.
  - `q_count` goes 0 → 1 → 0.
- **Dual enqueue ordering:** `enq_fid1 = 3`, `enq_fid2 = 9` in the same cycle, then `enq_fid1 = 4` next cycle.
  - Response: outputs in order 3, 9, 4 on consecutive cycles.
- **Pause:** queue holds {7, 8}; hold `tx_pause` high for 3 cycles.
  - Response: `tx_fid_out = NONE` and `q_count = 2` throughout.
  - After release, 7 then 8.
- **Full:**
  - Step 1: fill to `DEPTH = 1024` with `tx_pause` high, then offer `enq_fid1 = 11` and `enq_fid2 = 12`.
  - Response: both dropped, `q_overflow = 1`, `q_count = 1024`.
  - Step 2: drop `tx_pause` and offer fid1 = 13, fid2 = 14 in one cycle.
  - Response: only 13 accepted; `q_count` stays 1024.
- **Wrap-around:** stream 3000 IDs at one per cycle, with a two-per-cycle enqueue burst in the middle.
  - Response: output order equals input order; no loss; `q_overflow = 0`.
- **Async reset:** assert `rst_n` low mid-stream, between edges.
  - Response: `tx_fid_out = NONE` and `q_count = 0` immediately.
  - After release with no enqueues, output stays `NONE`.
